// File: rtl/fb_write_scheduler_pkg.sv
// Shared VGA framebuffer definitions: default geometry, scheduler FSM states
// and the pixel record carried between drawing blocks and the write port.
package fb_write_scheduler_pkg;

  localparam int FB_X_W       = 8;
  localparam int FB_Y_W       = 8;
  localparam int FB_COLOUR_W  = 3;
  localparam int FB_BG_COLOUR = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } fsm_state_t;

  typedef struct packed {
    logic [FB_X_W-1:0]      x;
    logic [FB_Y_W-1:0]      y;
    logic [FB_COLOUR_W-1:0] colour;
  } pixel_t;

  // Any state other than IDLE belongs to a clear sequence.
  function automatic logic is_clearing(fsm_state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Bundle of clear-engine, draw-requester and framebuffer plot signals around
// the write scheduler; slave is the scheduler side, master is its environment.
interface fb_write_scheduler_if #(
  parameter int X_W      = fb_write_scheduler_pkg::FB_X_W,
  parameter int Y_W      = fb_write_scheduler_pkg::FB_Y_W,
  parameter int COLOUR_W = fb_write_scheduler_pkg::FB_COLOUR_W
);

  logic                clear_req;
  logic                clear_busy;
  logic                clear_done;

  logic                clr_reset;
  logic                clr_enable;
  logic [X_W-1:0]      clr_x;
  logic [Y_W-1:0]      clr_y;
  logic                clr_finished;

  logic                d0_valid;
  logic                d0_ready;
  logic [X_W-1:0]      d0_x;
  logic [Y_W-1:0]      d0_y;
  logic [COLOUR_W-1:0] d0_colour;

  logic                d1_valid;
  logic                d1_ready;
  logic [X_W-1:0]      d1_x;
  logic [Y_W-1:0]      d1_y;
  logic [COLOUR_W-1:0] d1_colour;

  logic                fb_plot;
  logic [X_W-1:0]      fb_x;
  logic [Y_W-1:0]      fb_y;
  logic [COLOUR_W-1:0] fb_colour;

  modport slave (
    input  clear_req, clr_x, clr_y, clr_finished,
           d0_valid, d0_x, d0_y, d0_colour,
           d1_valid, d1_x, d1_y, d1_colour,
    output clear_busy, clear_done, clr_reset, clr_enable,
           d0_ready, d1_ready,
           fb_plot, fb_x, fb_y, fb_colour
  );

  modport master (
    output clear_req, clr_x, clr_y, clr_finished,
           d0_valid, d0_x, d0_y, d0_colour,
           d1_valid, d1_x, d1_y, d1_colour,
    input  clear_busy, clear_done, clr_reset, clr_enable,
           d0_ready, d1_ready,
           fb_plot, fb_x, fb_y, fb_colour
  );

endinterface

// File: rtl/fb_write_scheduler_arbiter.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the requester that did not win last. Grants are combinational.
module fb_rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  // 0: requester 0 won last, 1: requester 1 won last
  logic last_grant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (enable) begin
      if (valid0 && valid1) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Owner of the single framebuffer write port: runs the clear engine with
// absolute priority and otherwise feeds round-robin draw pixels, one per cycle.
module fb_write_scheduler
  import fb_write_scheduler_pkg::*;
#(
  parameter int X_W       = FB_X_W,
  parameter int Y_W       = FB_Y_W,
  parameter int COLOUR_W  = FB_COLOUR_W,
  parameter int BG_COLOUR = FB_BG_COLOUR
) (
  input  logic                  clk,
  input  logic                  reset,
  fb_write_scheduler_if.slave   bus
);

  localparam logic [COLOUR_W-1:0] BG = COLOUR_W'(BG_COLOUR);

  fsm_state_t          state;
  fsm_state_t          state_nxt;
  logic                clear_pending;
  logic                clear_pending_nxt;
  logic                arb_en;
  logic                grant0;
  logic                grant1;
  logic                sweep_pix;

  logic                plot_p1;
  logic [X_W-1:0]      x_p1;
  logic [Y_W-1:0]      y_p1;
  logic [COLOUR_W-1:0] colour_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      clear_pending <= 1'b0;
    end else begin
      state         <= state_nxt;
      clear_pending <= clear_pending_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    clear_pending_nxt = clear_pending;
    arb_en            = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear_req || clear_pending) begin
          state_nxt = ARM;
        end else begin
          // reset is folded in so ready stays low while reset is held
          arb_en = reset;
        end
      end
      ARM:   state_nxt = SWEEP;
      SWEEP: if (bus.clr_finished) state_nxt = DONE;
      DONE:  state_nxt = clear_pending ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
    // Requests arriving mid-sequence collapse into one follow-up clear.
    if (is_clearing(state) && bus.clear_req) begin
      clear_pending_nxt = 1'b1;
    end
    if (state_nxt == ARM) begin
      clear_pending_nxt = 1'b0;
    end
  end

  fb_rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .enable (arb_en),
    .valid0 (bus.d0_valid),
    .valid1 (bus.d1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign sweep_pix = (state == SWEEP) && !bus.clr_finished;

  // Stage p0 -> p1: the selected pixel is registered onto the write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      plot_p1   <= 1'b0;
      x_p1      <= '0;
      y_p1      <= '0;
      colour_p1 <= '0;
    end else begin
      plot_p1 <= sweep_pix || grant0 || grant1;
      if (sweep_pix) begin
        x_p1      <= bus.clr_x;
        y_p1      <= bus.clr_y;
        colour_p1 <= BG;
      end else if (grant0) begin
        x_p1      <= bus.d0_x;
        y_p1      <= bus.d0_y;
        colour_p1 <= bus.d0_colour;
      end else if (grant1) begin
        x_p1      <= bus.d1_x;
        y_p1      <= bus.d1_y;
        colour_p1 <= bus.d1_colour;
      end
    end
  end

  assign bus.fb_plot    = plot_p1;
  assign bus.fb_x       = x_p1;
  assign bus.fb_y       = y_p1;
  assign bus.fb_colour  = colour_p1;

  assign bus.d0_ready   = grant0;
  assign bus.d1_ready   = grant1;

  assign bus.clr_reset  = (state == ARM);
  assign bus.clr_enable = (state == SWEEP);
  assign bus.clear_busy = is_clearing(state);
  assign bus.clear_done = (state == DONE);

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Owns the single framebuffer write port of the VGA pipeline.
- Sequences the screen-clear engine (the x/y sweep block with enable/finished) and shares the port between the clear sweep and two pixel-draw requesters.
- Clear has absolute priority; the draw requesters are round-robin arbitrated at one pixel per cycle.
- Sits between the clear engine/drawing engines and the VGA adapter plot interface.

Parameters:
- X_W, 8, framebuffer x coordinate width
- Y_W, 8, framebuffer y coordinate width
- COLOUR_W, 3, pixel colour width
- BG_COLOUR, 0, colour written during a clear sweep

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear_req  in  1  request a full-screen clear (level or pulse)
- clear_busy  out  1  clear sequence in progress
- clear_done  out  1  one-cycle pulse when a clear sequence completes
- clr_reset  out  1  re-arm strobe to clear engine (active-high, one cycle)
- clr_enable  out  1  enable to clear engine
- clr_x  in  X_W  clear engine current x
- clr_y  in  Y_W  clear engine current y
- clr_finished  in  1  clear engine sweep complete
- d0_valid  in  1  requester 0 has a pixel
- d0_ready  out  1  requester 0 pixel accepted this cycle
- d0_x, d0_y, d0_colour  in  X_W / Y_W / COLOUR_W  requester 0 pixel
- d1_valid  in  1  requester 1 has a pixel
- d1_ready  out  1  requester 1 pixel accepted this cycle
- d1_x, d1_y, d1_colour  in  X_W / Y_W / COLOUR_W  requester 1 pixel
- fb_plot  out  1  write strobe to framebuffer
- fb_x, fb_y, fb_colour  out  X_W / Y_W / COLOUR_W  write address and data

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0.
  - State is IDLE, clear_pending=0, last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, ARM, SWEEP, DONE.
- IDLE:
  - If clear_req or clear_pending is set, go to ARM. No draw grant is given that cycle.
  - Otherwise arbitrate draws.
- ARM (1 cycle): clr_reset=1, clr_enable=0, clear_busy=1; go to SWEEP.
- SWEEP: clr_enable=1, clear_busy=1.
  - Each cycle with clr_finished=0: register fb_plot=1, fb_x=clr_x, fb_y=clr_y, fb_colour=BG_COLOUR.
  - Cycle with clr_finished=1: no plot, clr_enable drops next cycle, go to DONE.
- DONE (1 cycle):
  - clear_done=1, clear_busy=1.
  - Go to ARM if clear_pending is set, otherwise to IDLE.
- Draw arbitration (IDLE only, not while clear_req or clear_pending is high):
  - At most one dX_ready per cycle. dX_ready is combinational from valid and state.
  - Handshake completes when valid and ready are both 1 in the same cycle.
  - Only one valid: grant it.
  - Both valid: grant the requester that was not last_grant; update last_grant on every grant.
  - Accepted pixel appears on fb_* with fb_plot=1 on the next cycle (1-cycle latency).
  - All fb_* outputs are registered.
- fb_plot is 0 in any cycle with no grant or sweep pixel. fb_x/fb_y/fb_colour hold their last value when fb_plot=0.
- clear_pending:
  - Set by clear_req while in ARM, SWEEP or DONE.
  - Cleared on entry to ARM.
  - Multiple requests during one sweep coalesce into one extra clear.
- Requesters holding valid through a clear are stalled (ready=0). The first grant is issued in the first IDLE cycle after DONE.
- Simultaneous clear_req and draw valids in IDLE: clear wins, no draw accepted that cycle.
- Asynchronous reset mid-SWEEP: clr_enable and fb_plot drop immediately; the pending clear is discarded.
- Coordinates pass through unmodified. No range check or wrap; the clear engine owns the sweep bounds.
- Sweep throughput: 1 pixel per cycle. Total clear cost = sweep pixel count + 3 cycles (ARM, finished cycle, DONE).

Decomposition:
- Shared VGA package contains:
  - X_W, Y_W, COLOUR_W, BG_COLOUR defaults
  - FSM state enum (IDLE/ARM/SWEEP/DONE)
  - pixel struct {x, y, colour}
- One natural sub-module: fb_rr_arbiter2. It is a 2-way round-robin arbiter with last_grant state, inputs valid0/valid1/enable, outputs grant0/grant1.

Test Plan:
- Reset then a single draw: d0_valid=1, (10,20,5) -> d0_ready=1 in the same cycle. Next cycle fb_plot=1, fb_x=10, fb_y=20, fb_colour=5. fb_plot=0 afterwards once d0_valid drops.
- Contention: d0_valid and d1_valid held for 4 cycles -> grants alternate 0,1,0,1. fb_plot=1 on 4 consecutive cycles, each one cycle after its grant.
- Clear sequence: pulse clear_req with a clear-engine model sweeping 4x4 -> clr_reset pulse, then clr_enable high. 16 fb_plot cycles with fb_colour=0 follow, then clear_done pulses once and clear_busy=0.
- Clear vs draw: d1_valid held and clear_req asserted in the same IDLE cycle -> d1_ready stays 0 through the whole sweep. d1 is granted in the first cycle after DONE.
- Coalescing: clear_req pulsed 3 times during SWEEP -> exactly one extra ARM/SWEEP/DONE follows, giving 2 clear_done pulses total.
- Asynchronous reset during SWEEP (mid-sweep, not clock-aligned) -> clr_enable, fb_plot and clear_busy go to 0 immediately. No clear_done is issued, and the block is in IDLE after release.
